scoreboard_hazard_unit: RTL and testbench

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/scoreboard_hazard_unit.sv | 164 ++++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, mul/div occupancy FSM, mispredict flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module scoreboard_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic [1:0]            d_rs_used,
  input  logic [REG_ADDR_W-1:0] e_rs1,
  input  logic [REG_ADDR_W-1:0] e_rs2,
  input  logic [1:0]            e_rs_used,
  input  logic [REG_ADDR_W-1:0] e_rd,
  input  logic                  e_is_load,
  input  logic                  e_is_md,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  m_we,
  input  logic                  m_is_load,
  input  logic [REG_ADDR_W-1:0] w_rd,
  input  logic                  w_we,
  input  logic                  mispredict,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  PC_en,
  output logic                  F_D_en,
  output logic                  D_E_en,
  output logic                  no_op,
  output logic                  em_bubble,
  output logic                  Flush,
  output logic [PERF_W-1:0]     perf_stall_cycles,
  output logic [PERF_W-1:0]     perf_flush_count,
  output logic                  dbg_md_busy
);

  localparam int CNT_W = (MD_LATENCY <= 2) ? 1 : $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // A load still in M has no data yet, so it falls through to the W check.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic used);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (used && (rs != '0) && (rs == m_rd) && m_we && !m_is_load) begin
      sel = FWD_MEM;
    end else if ((rs != '0) && (rs == w_rd) && w_we) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(e_rs1, e_rs_used[0]);
    fwd_b = fwd_sel(e_rs2, e_rs_used[1]);
  end

  always_comb begin
    load_use = e_is_load && (e_rd != '0) &&
               (((d_rs1 == e_rd) && d_rs_used[0]) || ((d_rs2 == e_rd) && d_rs_used[1]));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    PC_en     = 1'b1;
    F_D_en    = 1'b1;
    D_E_en    = 1'b1;
    no_op     = 1'b0;
    em_bubble = 1'b0;
    Flush     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (e_is_md) begin
          PC_en     = 1'b0;
          F_D_en    = 1'b0;
          D_E_en    = 1'b0;
          em_bubble = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = MD_BUSY;
        end else if (mispredict) begin
          Flush = 1'b1;
          no_op = 1'b1;
        end else if (load_use) begin
          PC_en  = 1'b0;
          F_D_en = 1'b0;
          D_E_en = 1'b0;
          no_op  = 1'b1;
        end
      end
      MD_BUSY: begin
        // The release cycle (counter at zero) lets the pipeline advance normally.
        if (cnt_q != '0) begin
          PC_en     = 1'b0;
          F_D_en    = 1'b0;
          D_E_en    = 1'b0;
          em_bubble = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_md_busy = (state_q == MD_BUSY);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (Flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: vector table, corner sequences, random vs model.
module tb_scoreboard_hazard_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int PW  = 32;

  // Output word layout: {fwd_a, fwd_b, PC_en, F_D_en, D_E_en, no_op, em_bubble, Flush}
  localparam logic [5:0] CTL_NORM  = 6'b111000;
  localparam logic [5:0] CTL_LU    = 6'b000100;
  localparam logic [5:0] CTL_MP    = 6'b111101;
  localparam logic [5:0] CTL_MD    = 6'b000010;

  typedef struct {
    logic [AW-1:0] d_rs1, d_rs2;
    logic [1:0]    d_used;
    logic [AW-1:0] e_rs1, e_rs2;
    logic [1:0]    e_used;
    logic [AW-1:0] e_rd;
    logic          e_ld, e_md;
    logic [AW-1:0] m_rd;
    logic          m_we, m_ld;
    logic [AW-1:0] w_rd;
    logic          w_we, mp;
  } in_t;

  typedef struct {
    in_t        in;
    logic [9:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic [1:0]    d_rs_used, e_rs_used;
  logic          e_is_load, e_is_md, m_we, m_is_load, w_we, mispredict;
  logic [1:0]    fwd_a, fwd_b;
  logic          PC_en, F_D_en, D_E_en, no_op, em_bubble, Flush, dbg_md_busy;
  logic [PW-1:0] perf_stall_cycles, perf_flush_count;

  int total = 0;
  int bad   = 0;
  int busy_left = 0;
  logic [PW-1:0] m_stall = '0, m_flush = '0;
  logic [9:0] exp_q[$];

  scoreboard_hazard_unit #(.REG_ADDR_W(AW), .MD_LATENCY(LAT), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs_used(d_rs_used),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rs_used(e_rs_used), .e_rd(e_rd),
    .e_is_load(e_is_load), .e_is_md(e_is_md),
    .m_rd(m_rd), .m_we(m_we), .m_is_load(m_is_load),
    .w_rd(w_rd), .w_we(w_we), .mispredict(mispredict),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .PC_en(PC_en), .F_D_en(F_D_en), .D_E_en(D_E_en),
    .no_op(no_op), .em_bubble(em_bubble), .Flush(Flush),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
    .dbg_md_busy(dbg_md_busy)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input int d1, input int d2, input int du,
                             input int e1, input int e2, input int eu, input int erd,
                             input int eld, input int emd, input int mrd, input int mwe,
                             input int mld, input int wrd, input int wwe, input int mp);
    in_t r;
    r.d_rs1 = AW'(d1); r.d_rs2 = AW'(d2); r.d_used = 2'(du);
    r.e_rs1 = AW'(e1); r.e_rs2 = AW'(e2); r.e_used = 2'(eu); r.e_rd = AW'(erd);
    r.e_ld = 1'(eld); r.e_md = 1'(emd);
    r.m_rd = AW'(mrd); r.m_we = 1'(mwe); r.m_ld = 1'(mld);
    r.w_rd = AW'(wrd); r.w_we = 1'(wwe); r.mp = 1'(mp);
    return r;
  endfunction

  // Reference: forwarding source picked by the youngest producer that already holds data.
  function automatic logic [1:0] ref_fwd(input in_t i, input logic [AW-1:0] rs, input logic used);
    if (rs == 0) return 2'b00;
    if (used && i.m_we && !i.m_ld && rs == i.m_rd) return 2'b01;
    if (i.w_we && rs == i.w_rd) return 2'b10;
    return 2'b00;
  endfunction

  // busy_left counts the remaining occupancy cycles of a mul/div after the start cycle.
  function automatic logic [9:0] ref_out(input in_t i, input int left);
    logic [5:0] ctl;
    logic lu;
    lu = i.e_ld && i.e_rd != 0 &&
         ((i.d_used[0] && i.d_rs1 == i.e_rd) || (i.d_used[1] && i.d_rs2 == i.e_rd));
    if (left == 0 && i.e_md) ctl = CTL_MD;
    else if (left > 1)       ctl = CTL_MD;
    else if (left == 1)      ctl = CTL_NORM;
    else if (i.mp)           ctl = CTL_MP;
    else if (lu)             ctl = CTL_LU;
    else                     ctl = CTL_NORM;
    return {ref_fwd(i, i.e_rs1, i.e_used[0]), ref_fwd(i, i.e_rs2, i.e_used[1]), ctl};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] dut_out();
    return {fwd_a, fwd_b, PC_en, F_D_en, D_E_en, no_op, em_bubble, Flush};
  endfunction

  // Drive one cycle, check state/counters against the model, queue the model's output
  // expectation, then advance the model across the coming clock edge.
  task automatic apply(input in_t i, input logic rst_v, input string name);
    logic [9:0] e;
    @(negedge clk);
    rst_n = rst_v;
    d_rs1 = i.d_rs1; d_rs2 = i.d_rs2; d_rs_used = i.d_used;
    e_rs1 = i.e_rs1; e_rs2 = i.e_rs2; e_rs_used = i.e_used; e_rd = i.e_rd;
    e_is_load = i.e_ld; e_is_md = i.e_md;
    m_rd = i.m_rd; m_we = i.m_we; m_is_load = i.m_ld;
    w_rd = i.w_rd; w_we = i.w_we; mispredict = i.mp;
    #1;
    e = ref_out(i, busy_left);
    exp_q.push_back(e);
    check({name, ":busy"}, PW'(dbg_md_busy), PW'(busy_left != 0));
`ifdef HAZARD_PERF_EN
    check({name, ":stalls"}, perf_stall_cycles, m_stall);
    check({name, ":flushes"}, perf_flush_count, m_flush);
`else
    check({name, ":stalls"}, perf_stall_cycles, '0);
    check({name, ":flushes"}, perf_flush_count, '0);
`endif
    if (!rst_v) begin
      busy_left = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (e[5] == 1'b0 && m_stall != '1) m_stall = m_stall + 1'b1;
      if (e[0] == 1'b1 && m_flush != '1) m_flush = m_flush + 1'b1;
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (i.e_md) busy_left = LAT - 1;
    end
  endtask

  // Compare outputs against a hand-written value and drop the model's queued entry.
  task automatic check_hand(input string name, input logic [9:0] exp);
    logic [9:0] m;
    m = exp_q.pop_front();
    check(name, PW'(dut_out()), PW'(exp));
  endtask

  task automatic check_model(input string name);
    logic [9:0] m;
    m = exp_q.pop_front();
    check(name, PW'(dut_out()), PW'(m));
  endtask

  vec_t vecs[14];
  in_t  z;

  initial begin
    z = mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0);
    vecs[0]  = '{mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0), {4'b0000, CTL_NORM}};
    vecs[1]  = '{mk(0,0,0, 7,0,1,0, 0,0, 7,1,0, 7,1,0), {4'b0100, CTL_NORM}};
    vecs[2]  = '{mk(0,0,0, 7,0,1,0, 0,0, 7,1,1, 7,1,0), {4'b1000, CTL_NORM}};
    vecs[3]  = '{mk(0,0,0, 0,0,1,0, 0,0, 0,1,0, 0,1,0), {4'b0000, CTL_NORM}};
    vecs[4]  = '{mk(0,0,0, 0,9,2,0, 0,0, 9,1,0, 0,0,0), {4'b0001, CTL_NORM}};
    vecs[5]  = '{mk(0,0,0, 0,9,2,0, 0,0, 3,1,0, 9,1,0), {4'b0010, CTL_NORM}};
    vecs[6]  = '{mk(0,0,0, 6,0,1,0, 0,0, 6,0,0, 2,1,0), {4'b0000, CTL_NORM}};
    vecs[7]  = '{mk(0,0,0, 6,0,0,0, 0,0, 6,1,0, 4,1,0), {4'b0000, CTL_NORM}};
    vecs[8]  = '{mk(5,0,1, 0,0,0,5, 1,0, 0,0,0, 0,0,0), {4'b0000, CTL_LU}};
    vecs[9]  = '{mk(5,0,2, 0,0,0,5, 1,0, 0,0,0, 0,0,0), {4'b0000, CTL_NORM}};
    vecs[10] = '{mk(0,0,1, 0,0,0,0, 1,0, 0,0,0, 0,0,0), {4'b0000, CTL_NORM}};
    vecs[11] = '{mk(5,0,1, 0,0,0,5, 1,0, 0,0,0, 0,0,1), {4'b0000, CTL_MP}};
    vecs[12] = '{mk(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,1), {4'b0000, CTL_MP}};
    vecs[13] = '{mk(0,0,0, 3,3,3,0, 0,0, 3,1,0, 0,0,0), {4'b0101, CTL_NORM}};

    apply(z, 1'b0, "rst0");
    check_hand("rst0", {4'b0000, CTL_NORM});
    apply(z, 1'b0, "rst1");
    check_hand("rst1", {4'b0000, CTL_NORM});
    apply(z, 1'b1, "after_rst");
    check_hand("after_rst", {4'b0000, CTL_NORM});

    for (int k = 0; k < 14; k++) begin
      apply(vecs[k].in, 1'b1, $sformatf("vec%0d", k));
      check_hand($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Load x5 in E, consumer reads x5 via rs2; one stall, then W forwarding.
    apply(mk(0,5,2, 0,0,0,5, 1,0, 0,0,0, 0,0,0), 1'b1, "lu_stall");
    check_hand("lu_stall", {4'b0000, CTL_LU});
    apply(mk(0,5,2, 0,0,0,0, 0,0, 5,1,1, 0,0,0), 1'b1, "lu_bubble");
    check_hand("lu_bubble", {4'b0000, CTL_NORM});
    apply(mk(0,0,0, 0,5,2,0, 0,0, 0,0,0, 5,1,0), 1'b1, "lu_fwd_wb");
    check_hand("lu_fwd_wb", {4'b0010, CTL_NORM});

    // Mul/div occupancy with a mispredict at start and mid-stall (both ignored).
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,1), 1'b1, "md_start");
    check_hand("md_start", {4'b0000, CTL_MD});
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,1), 1'b1, "md_busy1");
    check_hand("md_busy1", {4'b0000, CTL_MD});
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,0), 1'b1, "md_busy2");
    check_hand("md_busy2", {4'b0000, CTL_MD});
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,1), 1'b1, "md_release");
    check_hand("md_release", {4'b0000, CTL_NORM});
    apply(z, 1'b1, "md_idle");
    check_hand("md_idle", {4'b0000, CTL_NORM});
    check("md_idle_state", PW'(dbg_md_busy), '0);

    // Reset in the second BUSY cycle returns to IDLE with counters cleared.
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,0), 1'b1, "rb_start");
    check_hand("rb_start", {4'b0000, CTL_MD});
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,0), 1'b1, "rb_busy1");
    check_hand("rb_busy1", {4'b0000, CTL_MD});
    apply(mk(0,0,0, 0,0,0,0, 0,1, 0,0,0, 0,0,0), 1'b0, "rb_reset");
    check_hand("rb_reset", {4'b0000, CTL_MD});
    apply(z, 1'b1, "rb_after");
    check_hand("rb_after", {4'b0000, CTL_NORM});
    check("rb_after_state", PW'(dbg_md_busy), '0);
    check("rb_after_stalls", perf_stall_cycles, '0);
    check("rb_after_flushes", perf_flush_count, '0);

    for (int n = 0; n < 600; n++) begin
      in_t r;
      r = mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,3),
             $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,3), $urandom_range(0,7),
             ($urandom_range(0,2) == 0), ($urandom_range(0,9) == 0),
             $urandom_range(0,7), $urandom_range(0,1), ($urandom_range(0,3) == 0),
             $urandom_range(0,7), $urandom_range(0,1), ($urandom_range(0,5) == 0));
      if (busy_left != 0) r.e_ld = 1'b0;
      apply(r, ($urandom_range(0,79) != 0), $sformatf("rnd%0d", n));
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
